// File: rtl/alu_result_stage_if.sv
// Handshake bundle for alu_result_stage: upstream result/flags in, registered result/flags out.
// master drives the upstream side and consumer ready; slave is the stage itself.
interface alu_result_stage_if #(
  parameter int size  = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [size-1:0]  in_res;
  logic             in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [size-1:0]  out_res;
  logic [2:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_op, in_res, in_carry, out_ready,
    input  in_ready, out_valid, out_res, out_op, out_zero, out_neg, out_carry, out_cnt
  );

  modport slave (
    input  in_valid, in_op, in_res, in_carry, out_ready,
    output in_ready, out_valid, out_res, out_op, out_zero, out_neg, out_carry, out_cnt
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with 2-entry skid buffer, status flags and delivered-result counter.
// Define ALU_FLAGS_EN to store and drive the carry flag; otherwise out_carry is tied 0.
module alu_result_stage #(
  parameter int size  = 8,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [size-1:0]  main_res, skid_res;
  logic [2:0]       main_op, skid_op;
  logic             main_zero, skid_zero;
  logic             main_neg, skid_neg;

  logic accept, take;
  logic load_main_in, load_skid, load_main_skid;
  logic cap_zero, cap_neg;

  assign accept   = bus.in_valid & in_ready_q;
  assign take     = out_valid_q & bus.out_ready;
  assign cap_zero = ~|bus.in_res;
  assign cap_neg  = bus.in_res[size-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !take)      state_d = FULL;
        else if (!accept && take) state_d = EMPTY;
      end
      FULL:  if (take) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
    case (state_q)
      EMPTY: load_main_in = accept;
      ONE: begin
        load_main_in = accept & take;
        load_skid    = accept & ~take;
      end
      FULL:  load_main_skid = take;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_res  <= '0;
      main_op   <= '0;
      main_zero <= 1'b0;
      main_neg  <= 1'b0;
      skid_res  <= '0;
      skid_op   <= '0;
      skid_zero <= 1'b0;
      skid_neg  <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_res  <= bus.in_res;
        main_op   <= bus.in_op;
        main_zero <= cap_zero;
        main_neg  <= cap_neg;
      end else if (load_main_skid) begin
        main_res  <= skid_res;
        main_op   <= skid_op;
        main_zero <= skid_zero;
        main_neg  <= skid_neg;
      end
      if (load_skid) begin
        skid_res  <= bus.in_res;
        skid_op   <= bus.in_op;
        skid_zero <= cap_zero;
        skid_neg  <= cap_neg;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic main_carry, skid_carry, cap_carry;

  // carry only meaningful for add (000) and sub (001)
  assign cap_carry = bus.in_carry & (bus.in_op[2:1] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_carry <= 1'b0;
      skid_carry <= 1'b0;
    end else begin
      if (load_main_in)        main_carry <= cap_carry;
      else if (load_main_skid) main_carry <= skid_carry;
      if (load_skid)           skid_carry <= cap_carry;
    end
  end

  assign bus.out_carry = main_carry;
`else
  assign bus.out_carry = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt_q <= '0;
    else if (take) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = main_res;
  assign bus.out_op    = main_op;
  assign bus.out_zero  = main_zero;
  assign bus.out_neg   = main_neg;
  assign bus.out_cnt   = cnt_q;

endmodule
